adder_seq_ctrl: RTL and testbench

ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

---
 rtl/adder_seq_ctrl.sv | 99 +++++++++
 tb/tb_adder_seq_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_seq_ctrl.sv
// Sequencer for an external 8-bit add/sub adder: latches operands, waits SETTLE_CYC cycles, captures result.
// Optional accumulate mode (acc_sel port) is enabled by defining ADDER_SEQ_ACC_EN.
module adder_seq_ctrl #(
  parameter int unsigned SETTLE_CYC = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic       in_mode,
`ifdef ADDER_SEQ_ACC_EN
  input  logic       acc_sel,
`endif
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  output logic       add_mode,
  input  logic [7:0] add_sum,
  input  logic       add_cout,
  input  logic       add_ovf,
  output logic [7:0] res_sum,
  output logic       res_cout,
  output logic       res_ovf,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  // A setting of 0 is treated like 1: capture on the first SETTLE edge.
  localparam logic [3:0] CNT_LOAD = (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       accept;
  logic [7:0] a_src;

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

`ifdef ADDER_SEQ_ACC_EN
  assign a_src = acc_sel ? res_sum : in_a;
`else
  assign a_src = in_a;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      add_a     <= 8'h00;
      add_b     <= 8'h00;
      add_mode  <= 1'b0;
      res_sum   <= 8'h00;
      res_cout  <= 1'b0;
      res_ovf   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        SETTLE: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            res_sum   <= add_sum;
            res_cout  <= add_cout;
            res_ovf   <= add_ovf;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: ;
      endcase
      // An accept overrides the DONE->IDLE move so back-to-back commands skip IDLE.
      if (accept) begin
        add_a    <= a_src;
        add_b    <= in_b;
        add_mode <= in_mode;
        cnt      <= CNT_LOAD;
        busy     <= 1'b1;
        state    <= SETTLE;
      end
    end
  end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl: three instances (SETTLE_CYC = 3, 0, 15) each driving a behavioural adder.
module tb_adder_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic       in_mode = 1'b0;
  logic       out_ready = 1'b0;
  logic       acc_sel = 1'b0;

  // index 0: SETTLE_CYC=3, 1: SETTLE_CYC=0, 2: SETTLE_CYC=15
  logic [2:0] in_ready, add_mode, add_cout, add_ovf, res_cout, res_ovf, out_valid, busy;
  logic [7:0] add_a [3];
  logic [7:0] add_b [3];
  logic [7:0] add_sum [3];
  logic [7:0] res_sum [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // External adder: add sets cout/ovf on carry, subtract flags ovf on borrow.
  function automatic logic [9:0] adder(input logic [7:0] a, input logic [7:0] b, input logic m);
    logic [8:0] s;
    if (m) begin
      s = {1'b0, a} + {1'b0, b};
      return {s[8], s[8], s[7:0]};
    end else begin
      s = {1'b0, a} + {1'b0, ~b} + 9'd1;
      return {~s[8], s[8], s[7:0]};
    end
  endfunction

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_dut
    adder_seq_ctrl #(.SETTLE_CYC(gi == 0 ? 3 : (gi == 1 ? 0 : 15))) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready[gi]),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_mode   (in_mode),
`ifdef ADDER_SEQ_ACC_EN
      .acc_sel   (acc_sel),
`endif
      .add_a     (add_a[gi]),
      .add_b     (add_b[gi]),
      .add_mode  (add_mode[gi]),
      .add_sum   (add_sum[gi]),
      .add_cout  (add_cout[gi]),
      .add_ovf   (add_ovf[gi]),
      .res_sum   (res_sum[gi]),
      .res_cout  (res_cout[gi]),
      .res_ovf   (res_ovf[gi]),
      .out_valid (out_valid[gi]),
      .out_ready (out_ready),
      .busy      (busy[gi])
    );
    assign {add_ovf[gi], add_cout[gi], add_sum[gi]} = adder(add_a[gi], add_b[gi], add_mode[gi]);
  end

  // Reference result from plain integer arithmetic.
  task automatic ref_model(input logic [7:0] a, input logic [7:0] b, input logic m,
                           output logic [7:0] es, output logic ec, output logic eo);
    int s;
    if (m) begin
      s  = int'(a) + int'(b);
      es = 8'(s);
      ec = (s > 255);
      eo = (s > 255);
    end else begin
      s  = int'(a) - int'(b);
      es = 8'(s);
      ec = (a >= b);
      eo = (a < b);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick;
    n_checks++;
    if ({add_a[0], add_b[0], add_mode[0], res_sum[0], res_cout[0], res_ovf[0], out_valid[0], busy[0], in_ready[0]}
        !== {8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: a=%h b=%h m=%b sum=%h c=%b o=%b ov=%b busy=%b rdy=%b, expected zeros with in_ready=1",
               add_a[0], add_b[0], add_mode[0], res_sum[0], res_cout[0], res_ovf[0], out_valid[0], busy[0], in_ready[0]);
    end
    #2 rst = 1'b0;
    tick;
    $display("reset: state checked");
  endtask

  // One complete command on the SETTLE_CYC=3 instance, from accept to consume.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic m, input string tag);
    logic [7:0] es;
    logic ec, eo, stable;
    int lat;
    ref_model(a, b, m, es, ec, eo);
    in_a = a; in_b = b; in_mode = m; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    n_checks++;
    if (in_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_in_ready: got %b expected 1", tag, in_ready[0]);
    end
    tick;
    in_valid = 1'b0;
    in_a = ~a; in_b = ~b; in_mode = ~m;
    n_checks++;
    if ({add_a[0], add_b[0], add_mode[0], busy[0], out_valid[0]} !== {a, b, m, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL %s_load: got a=%h b=%h m=%b busy=%b ov=%b expected a=%h b=%h m=%b busy=1 ov=0",
               tag, add_a[0], add_b[0], add_mode[0], busy[0], out_valid[0], a, b, m);
    end
    lat = 0;
    stable = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick;
      if ({add_a[0], add_b[0], add_mode[0]} !== {a, b, m}) stable = 1'b0;
      if (out_valid[0] === 1'b1) begin
        lat = k;
        break;
      end
    end
    n_checks++;
    if (lat != 3) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles expected 3", tag, lat);
    end
    n_checks++;
    if (stable !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_operand_hold: operands changed during settle, got %b expected 1", tag, stable);
    end
    n_checks++;
    if ({res_sum[0], res_cout[0], res_ovf[0], busy[0]} !== {es, ec, eo, 1'b0}) begin
      n_fail++;
      $display("FAIL %s_result: got sum=%h c=%b o=%b busy=%b expected sum=%h c=%b o=%b busy=0",
               tag, res_sum[0], res_cout[0], res_ovf[0], busy[0], es, ec, eo);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    #1;
    n_checks++;
    if ({out_valid[0], in_ready[0], res_sum[0]} !== {1'b0, 1'b1, es}) begin
      n_fail++;
      $display("FAIL %s_consume: got ov=%b rdy=%b sum=%h expected ov=0 rdy=1 sum=%h",
               tag, out_valid[0], in_ready[0], res_sum[0], es);
    end
    $display("op %s: a=%h b=%h mode=%b -> sum=%h cout=%b ovf=%b latency=%0d",
             tag, a, b, m, res_sum[0], res_cout[0], res_ovf[0], lat);
  endtask

  task automatic test_vectors;
    run_op(8'h05, 8'h03, 1'b1, "add_5_3");
    run_op(8'h05, 8'h03, 1'b0, "sub_5_3");
    run_op(8'hFF, 8'h01, 1'b1, "add_ff_1");
    run_op(8'h00, 8'h01, 1'b0, "sub_0_1");
  endtask

  task automatic test_random;
    for (int i = 0; i < 16; i++) begin
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), "rand");
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] es;
    logic ec, eo, held;
    int lat;
    in_a = 8'h05; in_b = 8'h03; in_mode = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    tick;
    in_valid = 1'b0;
    for (int k = 0; k < 40 && out_valid[0] !== 1'b1; k++) tick;
    in_a = 8'h20; in_b = 8'h07; in_mode = 1'b0; in_valid = 1'b1;
    held = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      if ({res_sum[0], out_valid[0], in_ready[0], add_a[0], add_b[0], add_mode[0]}
          !== {8'h08, 1'b1, 1'b0, 8'h05, 8'h03, 1'b1}) held = 1'b0;
    end
    n_checks++;
    if (held !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_done: got sum=%h ov=%b rdy=%b a=%h expected sum=08 ov=1 rdy=0 a=05 for 5 cycles",
               res_sum[0], out_valid[0], in_ready[0], add_a[0]);
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL done_ready: got in_ready=%b expected 1", in_ready[0]);
    end
    tick;
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if ({out_valid[0], busy[0], add_a[0], add_b[0], add_mode[0]} !== {1'b0, 1'b1, 8'h20, 8'h07, 1'b0}) begin
      n_fail++;
      $display("FAIL same_edge_accept: got ov=%b busy=%b a=%h b=%h m=%b expected ov=0 busy=1 a=20 b=07 m=0",
               out_valid[0], busy[0], add_a[0], add_b[0], add_mode[0]);
    end
    lat = 1;
    while (lat < 40 && out_valid[0] !== 1'b1) begin
      tick;
      if (out_valid[0] !== 1'b1) lat++;
    end
    n_checks++;
    if (lat != 3) begin
      n_fail++;
      $display("FAIL b2b_gap: got %0d low cycles expected 3", lat);
    end
    ref_model(8'h20, 8'h07, 1'b0, es, ec, eo);
    n_checks++;
    if ({res_sum[0], res_cout[0], res_ovf[0]} !== {es, ec, eo}) begin
      n_fail++;
      $display("FAIL b2b_result: got sum=%h c=%b o=%b expected sum=%h c=%b o=%b",
               res_sum[0], res_cout[0], res_ovf[0], es, ec, eo);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    $display("back_to_back: second result sum=%h gap=%0d", res_sum[0], lat);
  endtask

  task automatic test_reset_mid;
    logic quiet;
    in_a = 8'h44; in_b = 8'h11; in_mode = 1'b1; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({add_a[0], add_b[0], add_mode[0], res_sum[0], res_cout[0], res_ovf[0], out_valid[0], busy[0]}
        !== {8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got a=%h b=%h sum=%h ov=%b busy=%b expected all zero",
               add_a[0], add_b[0], res_sum[0], out_valid[0], busy[0]);
    end
    #2 rst = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick;
      if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) quiet = 1'b0;
    end
    n_checks++;
    if (quiet !== 1'b1) begin
      n_fail++;
      $display("FAIL no_capture_after_reset: got ov=%b busy=%b expected 0", out_valid[0], busy[0]);
    end
    $display("reset_mid: abandoned op, outputs cleared");
    run_op(8'h30, 8'h0C, 1'b1, "post_reset");
  endtask

  task automatic test_latency_extremes;
    int lat [3];
    logic stable [3];
    logic [7:0] es;
    logic ec, eo;
    rst = 1'b1;
    tick;
    #2 rst = 1'b0;
    tick;
    in_a = 8'h9C; in_b = 8'h64; in_mode = 1'b1; in_valid = 1'b1;
    tick;
    in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00;
    for (int d = 0; d < 3; d++) begin
      lat[d] = 0;
      stable[d] = 1'b1;
    end
    for (int k = 1; k <= 40; k++) begin
      tick;
      for (int d = 0; d < 3; d++) begin
        if ({add_a[d], add_b[d], add_mode[d]} !== {8'h9C, 8'h64, 1'b1}) stable[d] = 1'b0;
        if (lat[d] == 0 && out_valid[d] === 1'b1) lat[d] = k;
      end
    end
    n_checks++;
    if (lat[1] != 1) begin
      n_fail++;
      $display("FAIL latency_settle0: got %0d expected 1", lat[1]);
    end
    n_checks++;
    if (lat[2] != 15) begin
      n_fail++;
      $display("FAIL latency_settle15: got %0d expected 15", lat[2]);
    end
    n_checks++;
    if (stable[1] !== 1'b1 || stable[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL extreme_operand_hold: got stable0=%b stable15=%b expected 1 1", stable[1], stable[2]);
    end
    ref_model(8'h9C, 8'h64, 1'b1, es, ec, eo);
    n_checks++;
    if ({res_sum[2], res_cout[2], res_ovf[2]} !== {es, ec, eo}) begin
      n_fail++;
      $display("FAIL settle15_result: got sum=%h c=%b o=%b expected sum=%h c=%b o=%b",
               res_sum[2], res_cout[2], res_ovf[2], es, ec, eo);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    $display("latency: settle3=%0d settle0=%0d settle15=%0d", lat[0], lat[1], lat[2]);
  endtask

`ifdef ADDER_SEQ_ACC_EN
  task automatic test_acc;
    run_op(8'h10, 8'h01, 1'b1, "acc_seed");
    acc_sel = 1'b1; in_a = 8'hAA; in_b = 8'h01; in_mode = 1'b1; in_valid = 1'b1;
    tick;
    in_valid = 1'b0; acc_sel = 1'b0;
    n_checks++;
    if (add_a[0] !== 8'h11) begin
      n_fail++;
      $display("FAIL acc_load: got add_a=%h expected 11", add_a[0]);
    end
    for (int k = 0; k < 40 && out_valid[0] !== 1'b1; k++) tick;
    n_checks++;
    if (res_sum[0] !== 8'h12) begin
      n_fail++;
      $display("FAIL acc_result: got %h expected 12", res_sum[0]);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    $display("acc: add_a=11 result sum=%h", res_sum[0]);
  endtask
`endif

  initial begin
    test_reset;
    test_vectors;
    test_random;
    test_back_to_back;
    test_reset_mid;
    test_latency_extremes;
`ifdef ADDER_SEQ_ACC_EN
    test_acc;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
